// File: rtl/cache_pkg.sv
// Shared cache geometry constants and the line-fill FSM state encoding,
// used by the cache, the merge logic and the line fill buffer.
package cache_pkg;

    localparam int WORDS_PER_LINE = 8;
    localparam int WORD_W         = 32;
    localparam int ADDR_W         = 32;
    localparam int IDX_W          = $clog2(WORDS_PER_LINE);
    localparam int LINE_W         = WORD_W * WORDS_PER_LINE;

    typedef enum logic [1:0] {
        LFB_IDLE  = 2'd0,
        LFB_FETCH = 2'd1,
        LFB_DONE  = 2'd2
    } lfb_state_t;

endpackage

// File: rtl/line_fill_buffer.sv
// Fetches one cache line from word-wide memory (optionally critical-word-first),
// assembles it and reports first-word capture and line completion to the cache.
module line_fill_buffer
    import cache_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    input  logic              LB_Enable,
    input  logic [ADDR_W-1:0] Address,
    input  logic              RWordSelect,
    output logic              LB_Completed,
    output logic              LB_FirstWord,
    output logic [LINE_W-1:0] LB_LineData,
    output logic [ADDR_W-1:0] LB_LineAddr,
    output logic              Mem_Req,
    output logic [ADDR_W-1:0] Mem_Addr,
    input  logic              Mem_Ack,
    input  logic [WORD_W-1:0] Mem_RData,
    output lfb_state_t        dbg_state
);

    // Memory handshake: while Mem_Req is high, Mem_Addr is stable; a word
    // transfers in any cycle where Mem_Req and Mem_Ack are both high, and the
    // address advances to the next word in the following cycle.

    localparam logic [IDX_W:0] CNT_LAST = (IDX_W + 1)'(WORDS_PER_LINE - 1);

    lfb_state_t       state, next_state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W:0]   cnt;
    logic [LINE_W-1:0] line_data;
    logic [ADDR_W-1:0] line_addr;
    logic             first_word;
    logic             accept, capture;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= LFB_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            LFB_IDLE: begin
                if (LB_Enable) begin
                    accept     = 1'b1;
                    next_state = LFB_FETCH;
                end
            end
            LFB_FETCH: begin
                if (Mem_Ack) begin
                    capture = 1'b1;
                    if (cnt == CNT_LAST) next_state = LFB_DONE;
                end
            end
            LFB_DONE: next_state = LFB_IDLE;
            default:  next_state = LFB_IDLE;
        endcase
    end

    // Line register with per-word write enable; idx wraps naturally at the line end.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            idx        <= '0;
            cnt        <= '0;
            line_data  <= '0;
            line_addr  <= '0;
            first_word <= 1'b0;
        end else begin
            first_word <= capture && (cnt == '0);
            if (accept) begin
                line_addr <= {Address[ADDR_W-1:IDX_W], {IDX_W{1'b0}}};
                idx       <= RWordSelect ? Address[IDX_W-1:0] : '0;
                cnt       <= '0;
                line_data <= '0;
            end else if (capture) begin
                line_data[idx*WORD_W +: WORD_W] <= Mem_RData;
                idx <= idx + 1'b1;
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign Mem_Req      = (state == LFB_FETCH);
    assign Mem_Addr     = line_addr | {{(ADDR_W-IDX_W){1'b0}}, idx};
    assign LB_Completed = (state == LFB_DONE);
    assign LB_FirstWord = first_word;
    assign LB_LineData  = line_data;
    assign LB_LineAddr  = line_addr;
    assign dbg_state    = state;

endmodule

// File: tb/tb_line_fill_buffer.sv
// Directed-plus-random bench for line_fill_buffer: an arithmetic model of the
// fill order and line contents drives a scoreboard of expected request addresses.
module tb_line_fill_buffer;
    import cache_pkg::*;

    logic              Clk = 1'b0;
    logic              Rst;
    logic              LB_Enable;
    logic [ADDR_W-1:0] Address;
    logic              RWordSelect;
    logic              LB_Completed;
    logic              LB_FirstWord;
    logic [LINE_W-1:0] LB_LineData;
    logic [ADDR_W-1:0] LB_LineAddr;
    logic              Mem_Req;
    logic [ADDR_W-1:0] Mem_Addr;
    logic              Mem_Ack;
    logic [WORD_W-1:0] Mem_RData;
    lfb_state_t        dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [ADDR_W-1:0] exp_q[$];

    line_fill_buffer dut (
        .Clk(Clk), .Rst(Rst), .LB_Enable(LB_Enable), .Address(Address),
        .RWordSelect(RWordSelect), .LB_Completed(LB_Completed),
        .LB_FirstWord(LB_FirstWord), .LB_LineData(LB_LineData),
        .LB_LineAddr(LB_LineAddr), .Mem_Req(Mem_Req), .Mem_Addr(Mem_Addr),
        .Mem_Ack(Mem_Ack), .Mem_RData(Mem_RData), .dbg_state(dbg_state)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete fill starting from an IDLE negedge. Inputs change on negedges,
    // outputs are sampled on negedges.
    task automatic run_fill(input logic [ADDR_W-1:0] addr, input bit rws, input int max_wait,
                            input bit addr_data, input bit busy, input bit chain,
                            input logic [ADDR_W-1:0] chain_addr);
        logic [ADDR_W-1:0] base;
        logic [LINE_W-1:0] exp_line;
        logic [WORD_W-1:0] data;
        int start, slot, cyc, total_waits, w;
        bit first_next;
        base        = {addr[ADDR_W-1:IDX_W], {IDX_W{1'b0}}};
        start       = rws ? int'(addr[IDX_W-1:0]) : 0;
        exp_line    = '0;
        total_waits = 0;
        exp_q.delete();
        for (int k = 0; k < WORDS_PER_LINE; k++)
            exp_q.push_back(base + ADDR_W'((start + k) % WORDS_PER_LINE));

        LB_Enable = 1'b1; Address = addr; RWordSelect = rws;
        @(negedge Clk); cyc = 1;
        LB_Enable = 1'b0; Address = $urandom; RWordSelect = 1'($urandom);
        check("req_start", Mem_Req, 1);
        check("line_clear", LB_LineData, '0);
        check("line_addr", LB_LineAddr, base);
        first_next = 1'b0;

        for (int k = 0; k < WORDS_PER_LINE; k++) begin
            w = (max_wait > 0) ? $urandom_range(0, max_wait) : 0;
            total_waits += w;
            for (int j = 0; j < w; j++) begin
                Mem_Ack = 1'b0; Mem_RData = $urandom;
                check("addr_hold", Mem_Addr, exp_q[0]);
                check("first_word_wait", LB_FirstWord, first_next);
                check("no_complete_wait", LB_Completed, 0);
                first_next = 1'b0;
                @(negedge Clk); cyc++;
            end
            data = addr_data ? exp_q[0] : $urandom;
            Mem_Ack = 1'b1; Mem_RData = data;
            if (busy && k == 3) begin
                LB_Enable = 1'b1; Address = 32'h0000_0200;
            end
            check("mem_addr", Mem_Addr, exp_q[0]);
            check("mem_req", Mem_Req, 1);
            check("first_word", LB_FirstWord, first_next);
            check("no_complete", LB_Completed, 0);
            slot = (start + k) % WORDS_PER_LINE;
            exp_line[slot*WORD_W +: WORD_W] = data;
            first_next = (k == 0);
            void'(exp_q.pop_front());
            @(negedge Clk); cyc++;
            Mem_Ack = 1'b0; LB_Enable = 1'b0;
            if (k == 0) check("critical_word", LB_LineData[slot*WORD_W +: WORD_W], data);
            if (busy && k == 3) check("busy_line_addr", LB_LineAddr, base);
        end

        check("complete", LB_Completed, 1);
        check("req_drop", Mem_Req, 0);
        check("complete_cycle", cyc, 9 + total_waits);
        check("line_data", LB_LineData, exp_line);
        check("line_addr_done", LB_LineAddr, base);
        check("state_done", dbg_state, LFB_DONE);
        if (chain) begin
            LB_Enable = 1'b1; Address = chain_addr; RWordSelect = 1'b0;
        end
        @(negedge Clk);
        check("complete_pulse", LB_Completed, 0);
        check("idle_req", Mem_Req, 0);
        check("line_hold", LB_LineData, exp_line);
        check("state_idle", dbg_state, LFB_IDLE);
        if (!chain) begin
            @(negedge Clk);
            check("no_refill", Mem_Req, 0);
            check("line_hold2", LB_LineData, exp_line);
        end
    endtask

    initial begin
        Rst = 1'b1; LB_Enable = 1'b0; Address = '0; RWordSelect = 1'b0;
        Mem_Ack = 1'b0; Mem_RData = '0;
        repeat (2) @(negedge Clk);
        check("rst_req", Mem_Req, 0);
        check("rst_line", LB_LineData, '0);
        check("rst_addr", LB_LineAddr, '0);
        check("rst_complete", LB_Completed, 0);
        check("rst_first", LB_FirstWord, 0);
        Rst = 1'b0;
        @(negedge Clk);
        // Mem_Ack in IDLE must not start anything
        Mem_Ack = 1'b1; Mem_RData = 32'hdead_beef;
        @(negedge Clk);
        Mem_Ack = 1'b0;
        check("idle_ack_ignored", Mem_Req, 0);
        check("idle_ack_line", LB_LineData, '0);

        // Reset mid-fill after three acks
        LB_Enable = 1'b1; Address = 32'h0000_0345; RWordSelect = 1'b1;
        @(negedge Clk);
        LB_Enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            Mem_Ack = 1'b1; Mem_RData = $urandom;
            @(negedge Clk);
        end
        Mem_Ack = 1'b0;
        #2 Rst = 1'b1;
        #1;
        check("midrst_req", Mem_Req, 0);
        check("midrst_line", LB_LineData, '0);
        check("midrst_addr", LB_LineAddr, '0);
        check("midrst_complete", LB_Completed, 0);
        @(negedge Clk);
        Rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            Mem_Ack = 1'($urandom);
            @(negedge Clk);
            check("post_rst_complete", LB_Completed, 0);
            check("post_rst_req", Mem_Req, 0);
        end
        Mem_Ack = 1'b0;
        run_fill(32'h0000_0345, 1'b0, 0, 1'b0, 1'b0, 1'b0, '0);

        // Linear and critical-word-first fills with data = address
        run_fill(32'h0000_0105, 1'b0, 0, 1'b1, 1'b0, 1'b0, '0);
        run_fill(32'h0000_0105, 1'b1, 0, 1'b1, 1'b0, 1'b0, '0);

        // Random wait states and random addresses / order
        for (int n = 0; n < 6; n++)
            run_fill($urandom, 1'($urandom), 3, 1'b0, 1'b0, 1'b0, '0);

        // Request while busy is ignored
        run_fill(32'h0000_0100, 1'b0, 1, 1'b1, 1'b1, 1'b0, '0);

        // Back-to-back: enable held across DONE, second fill one cycle later
        run_fill(32'h0000_0100, 1'b1, 0, 1'b1, 1'b0, 1'b1, 32'h0000_0468);
        run_fill(32'h0000_0468, 1'b0, 2, 1'b0, 1'b0, 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
